datapath: RTL and testbench

Execution datapath driven by the 15-bit control word of the sequencer FSM. It holds a 16-entry register file, two operand multiplexers and a 2-bit-opcode ALU. It returns the registered unsigned comparison flag `mayor` that the FSM branches on. A host-side load port preloads operands, and a read port observes results, so the sequencer/datapath pair runs stand-alone on the SharkBoard.

---
 rtl/datapath_pkg.sv | 34 +++
 rtl/datapath_regfile.sv | 60 ++++++
 rtl/datapath.sv | 96 +++++++++
 tb/tb_datapath.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared constants for the sequencer/datapath pair: default
//               word width, register-file geometry, ALU opcodes and the
//               bit positions of every field in the 15-bit control word.
//               The sequencer FSM builds its control words from these too.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DP_WIDTH_DEFAULT = 8;

    // Register file geometry
    localparam int REG_COUNT  = 16;
    localparam int REG_ADDR_W = 4;

    // ALU opcodes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Control word layout: {cnt_alu, slc_mux_a, slc_mux_b, slc_reg, w}
    localparam int CTRL_W       = 15;
    localparam int CTRL_ALU_LSB = 13;
    localparam int CTRL_ALU_W   = 2;
    localparam int CTRL_A_LSB   = 9;
    localparam int CTRL_B_LSB   = 5;
    localparam int CTRL_DST_LSB = 1;
    localparam int CTRL_W_BIT   = 0;

endpackage
`default_nettype wire

// File: rtl/datapath_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 16 x WIDTH general-purpose register file, asynchronously
//               cleared. Two operand read ports plus one observation read
//               port, all combinational. Two write ports: the control-word
//               write and the host load; the host load wins when both
//               target the same index in the same cycle.
// Ports       : clk, rst          - clock, async active-high reset
//               i_we/i_waddr/i_wdata          - control write port
//               i_ld_en/i_ld_addr/i_ld_data   - host load port
//               i_ra_addr/o_ra_data           - operand A read
//               i_rb_addr/o_rb_data           - operand B read
//               i_rd_addr/o_rd_data           - observation read
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import datapath_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_ld_en,
    input  logic [REG_ADDR_W-1:0] i_ld_addr,
    input  logic [WIDTH-1:0]      i_ld_data,
    input  logic [REG_ADDR_W-1:0] i_ra_addr,
    input  logic [REG_ADDR_W-1:0] i_rb_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_ra_data,
    output logic [WIDTH-1:0]      o_rb_data,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [REG_COUNT];

    // One flop bank per entry; the load port is checked first so it takes
    // priority over the control write on an index collision.
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem[gi] <= '0;
            end else if (i_ld_en && (i_ld_addr == REG_ADDR_W'(gi))) begin
                r_mem[gi] <= i_ld_data;
            end else if (i_we && (i_waddr == REG_ADDR_W'(gi))) begin
                r_mem[gi] <= i_wdata;
            end
        end
    end

    // No write bypass: reads always see the pre-edge contents.
    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];
    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Execution datapath driven by the sequencer's 15-bit control
//               word: register file, A/B operand muxes, 2-bit-opcode ALU and
//               the registered unsigned A > B flag (mayor) the FSM branches
//               on. A host load port and an observation read port let the
//               pair run stand-alone.
// Ports       : clk, rst  - clock, async active-high reset
//               ctrl      - {alu op, A idx, B idx, dst idx, w}
//               mayor     - registered (A > B) from the previous cycle
//               ld_en/ld_addr/ld_data - host register load
//               rd_addr/rd_data       - combinational register observation
//               alu_out   - combinational ALU result for current ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_W-1:0]     ctrl,
    output logic                  mayor,
    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [WIDTH-1:0]      alu_out
);

    logic [CTRL_ALU_W-1:0] w_op;
    logic [REG_ADDR_W-1:0] w_sel_a;
    logic [REG_ADDR_W-1:0] w_sel_b;
    logic [REG_ADDR_W-1:0] w_sel_dst;
    logic                  w_we;
    logic [WIDTH-1:0]      w_op_a;
    logic [WIDTH-1:0]      w_op_b;
    logic [WIDTH-1:0]      w_alu;
    logic                  r_mayor;

    assign w_op      = ctrl[CTRL_ALU_LSB +: CTRL_ALU_W];
    assign w_sel_a   = ctrl[CTRL_A_LSB   +: REG_ADDR_W];
    assign w_sel_b   = ctrl[CTRL_B_LSB   +: REG_ADDR_W];
    assign w_sel_dst = ctrl[CTRL_DST_LSB +: REG_ADDR_W];
    assign w_we      = ctrl[CTRL_W_BIT];

    regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_sel_dst),
        .i_wdata   (w_alu),
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data),
        .i_ra_addr (w_sel_a),
        .i_rb_addr (w_sel_b),
        .i_rd_addr (rd_addr),
        .o_ra_data (w_op_a),
        .o_rb_data (w_op_b),
        .o_rd_data (rd_data)
    );

    // All results wrap modulo 2^WIDTH; carry/borrow is discarded.
    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD: w_alu = w_op_a + w_op_b;
            ALU_SUB: w_alu = w_op_a - w_op_b;
            ALU_AND: w_alu = w_op_a & w_op_b;
            ALU_OR:  w_alu = w_op_a | w_op_b;
            default: w_alu = '0;
        endcase
    end

    assign alu_out = w_alu;

    // Flag tracks the operand selects every cycle regardless of w, so the
    // FSM sees a valid compare one state after it sets the selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mayor <= 1'b0;
        end else begin
            r_mayor <= (w_op_a > w_op_b);
        end
    end

    assign mayor = r_mayor;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Directed self-checking bench for datapath (WIDTH = 8).
//               Inputs change on the falling edge; outputs are checked on
//               the falling edge, away from the active rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    logic        clk;
    logic        rst;
    logic [14:0] ctrl;
    logic        mayor;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  alu_out;

    int checks = 0;
    int errors = 0;

    datapath #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .mayor   (mayor),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .alu_out (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] d,
                                       input logic w);
        return {op, a, b, d, w};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full cycle: through the rising edge, back to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ctrl = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        ctrl = mk(2'b11, 4'd3, 4'd9, 4'd0, 1'b0);
        rd_addr = 4'd3;
        #1;
        chk("reset_rd", rd_data, 8'h00);
        chk("reset_mayor", {7'd0, mayor}, 8'h00);
        chk("reset_alu_or", alu_out, 8'h00);

        // Load R3 and build up a set flag, then reset mid-cycle
        @(negedge clk);
        load(4'd3, 8'h55);
        chk("load_r3", rd_data, 8'h55);
        ctrl = mk(2'b00, 4'd3, 4'd0, 4'd0, 1'b0);
        tick();
        chk("pre_rst_mayor", {7'd0, mayor}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rd", rd_data, 8'h00);
        chk("async_rst_mayor", {7'd0, mayor}, 8'h00);
        // A load pending at an edge during reset is dropped
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 8'h77;
        tick();
        rst = 1'b0; ld_en = 1'b0; ctrl = '0;
        #1;
        chk("rst_drop_load", rd_data, 8'h00);
        @(negedge clk);

        // Load + add
        load(4'd1, 8'h20);
        load(4'd2, 8'h05);
        ctrl = mk(2'b00, 4'd1, 4'd2, 4'd4, 1'b1);
        rd_addr = 4'd4;
        #1;
        chk("add_alu", alu_out, 8'h25);
        @(negedge clk);
        tick();
        chk("add_r4", rd_data, 8'h25);
        chk("add_mayor", {7'd0, mayor}, 8'h01);

        // Subtract wrap
        ctrl = '0;
        load(4'd1, 8'h03);
        ctrl = mk(2'b01, 4'd1, 4'd2, 4'd6, 1'b1);
        rd_addr = 4'd6;
        tick();
        chk("sub_wrap_r6", rd_data, 8'hFE);
        chk("sub_mayor", {7'd0, mayor}, 8'h00);

        // Add wrap
        ctrl = '0;
        load(4'd1, 8'hFF);
        load(4'd2, 8'h01);
        ctrl = mk(2'b00, 4'd1, 4'd2, 4'd8, 1'b1);
        rd_addr = 4'd8;
        tick();
        chk("add_wrap_r8", rd_data, 8'h00);
        chk("add_wrap_mayor", {7'd0, mayor}, 8'h01);

        // Unsigned compare boundary
        ctrl = '0;
        load(4'd1, 8'h80);
        load(4'd2, 8'h80);
        chk("ctrl_zero_mayor", {7'd0, mayor}, 8'h00);
        ctrl = mk(2'b10, 4'd1, 4'd2, 4'd0, 1'b0);
        tick();
        chk("cmp_equal", {7'd0, mayor}, 8'h00);
        load(4'd2, 8'h7F);
        tick();
        chk("cmp_unsigned", {7'd0, mayor}, 8'h01);

        // Same-edge conflict: load wins on R5; different indices both land
        ctrl = '0;
        load(4'd1, 8'h10);
        load(4'd2, 8'h01);
        ctrl = mk(2'b11, 4'd1, 4'd2, 4'd5, 1'b1);
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'hAA;
        #1;
        chk("conflict_alu", alu_out, 8'h11);
        @(negedge clk);
        tick();
        ld_en = 1'b0;
        rd_addr = 4'd5;
        #1;
        chk("conflict_r5", rd_data, 8'hAA);
        @(negedge clk);
        ctrl = mk(2'b11, 4'd1, 4'd2, 4'd10, 1'b1);
        ld_en = 1'b1; ld_addr = 4'd9; ld_data = 8'h3C;
        tick();
        ld_en = 1'b0; ctrl = '0;
        rd_addr = 4'd9;
        #1;
        chk("dual_r9", rd_data, 8'h3C);
        rd_addr = 4'd10;
        #1;
        chk("dual_r10", rd_data, 8'h11);
        @(negedge clk);

        // No bypass
        load(4'd7, 8'h01);
        ctrl = mk(2'b10, 4'd7, 4'd0, 4'd0, 1'b0);
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 8'h09;
        rd_addr = 4'd7;
        #1;
        chk("nobyp_alu", alu_out, 8'h00);
        chk("nobyp_rd_old", rd_data, 8'h01);
        @(negedge clk);
        tick();
        ld_en = 1'b0;
        chk("nobyp_mayor", {7'd0, mayor}, 8'h01);
        chk("nobyp_rd_new", rd_data, 8'h09);
        ctrl = mk(2'b11, 4'd7, 4'd0, 4'd0, 1'b0);
        #1;
        chk("nobyp_alu_new", alu_out, 8'h09);

        // All-zero control word clears the flag
        @(negedge clk);
        ctrl = '0;
        tick();
        chk("nop_mayor", {7'd0, mayor}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
